// File: rtl/sdr_resp_pkg.sv
// Shared definitions for the SDR SDRAM responder: command codes, mode-register
// field encodings and the per-bank state record.
// Purely declarative; no latency or flow control of its own.
package sdr_resp_pkg;

  // {ras_n, cas_n, we_n} command codes
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_BST = 3'b110;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_LMR = 3'b000;

  // Burst-length field, addr[2:0] of LOAD MODE
  localparam logic [2:0] BL_1    = 3'b000;
  localparam logic [2:0] BL_2    = 3'b001;
  localparam logic [2:0] BL_4    = 3'b010;
  localparam logic [2:0] BL_8    = 3'b011;
  localparam logic [2:0] BL_PAGE = 3'b111;

  // CAS-latency field, addr[6:4] of LOAD MODE
  localparam logic [2:0] CL_2 = 3'b010;
  localparam logic [2:0] CL_3 = 3'b011;

  // Row storage is sized for the widest supported address bus.
  localparam int ROW_MAX_W = 16;

  typedef struct packed {
    logic                 open;
    logic [ROW_MAX_W-1:0] row;
  } bank_t;

  function automatic logic bl_valid(input logic [2:0] f);
    return (f == BL_1) || (f == BL_2) || (f == BL_4) || (f == BL_8) || (f == BL_PAGE);
  endfunction

  // Burst length in words; full page is 2^col_w.
  function automatic logic [15:0] bl_len(input logic [2:0] f, input int col_w);
    logic [15:0] len;
    len = 16'd1;
    case (f)
      BL_2:    len = 16'd2;
      BL_4:    len = 16'd4;
      BL_8:    len = 16'd8;
      BL_PAGE: len = 16'd1 << col_w;
      default: len = 16'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/sdr_resp_mem.sv
// Single-port synchronous data array with byte write enables.
// Latency: read data registered, valid one cycle after the address edge.
// Backpressure: none; one access per cycle, read and write share the address.
// Ports: clk, addr, wr (write strobe), be (byte enables), wdata, rdata.
module sdr_resp_mem #(
  parameter int DATA_W = 32,
  parameter int AW     = 12
) (
  input  logic                  clk,
  input  logic [AW-1:0]         addr,
  input  logic                  wr,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdr_mem_responder.sv
// SDR SDRAM device-side responder: command decode, mode register, bank table,
// burst column counter and CAS-latency read pipeline (CL2/CL3), write absorb.
// Backpressure: none; the controller owns timing, illegal commands pulse cmd_err.
// Ports: clk, rst2 (async active-low), sdc_cs_n/ras_n/cas_n/we_n, sdc_ba, sdc_addr,
//   sdc_dq_i (write data), sdc_dq_o/sdc_dq_t (read data / drive enable), cmd_err.
// Optional macro SDC_DQM_EN adds sdc_dqm byte masks (write mask, 2-cycle read mask).
module sdr_mem_responder
  import sdr_resp_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 12,
  parameter int COL_W    = 8,
  parameter int ROW_BITS = 2,
  parameter int BANKS    = 4
) (
  input  logic                       clk,
  input  logic                       rst2,
  input  logic                       sdc_cs_n,
  input  logic                       sdc_ras_n,
  input  logic                       sdc_cas_n,
  input  logic                       sdc_we_n,
  input  logic [$clog2(BANKS)-1:0]   sdc_ba,
  input  logic [ADDR_W-1:0]          sdc_addr,
  input  logic [DATA_W-1:0]          sdc_dq_i,
  output logic [DATA_W-1:0]          sdc_dq_o,
  output logic                       sdc_dq_t,
  output logic                       cmd_err
`ifdef SDC_DQM_EN
  ,
  input  logic [DATA_W/8-1:0]        sdc_dqm
`endif
);

  localparam int BA_W  = $clog2(BANKS);
  localparam int LEN_W = COL_W + 1;
  localparam int AW    = BA_W + ROW_BITS + COL_W;
  localparam int NB    = DATA_W / 8;

  // ---------------- state ----------------
  bank_t              bank_tab [BANKS];
  logic               cl3;
  logic [LEN_W-1:0]   mode_len;

  logic               burst_act;
  logic               b_wr;
  logic [BA_W-1:0]    b_bank;
  logic [ROW_BITS-1:0] b_row;
  logic [COL_W-1:0]   b_col;
  logic [LEN_W-1:0]   b_idx;
  logic [LEN_W-1:0]   b_len;

  logic               v0, v1;
  logic [DATA_W-1:0]  d1;
  logic [DATA_W-1:0]  mem_rdata;

  // ---------------- decode ----------------
  logic [2:0]         cmd;
  logic               any_open, tgt_open, lmr_ok;
  logic               err_now, new_rd, new_wr, bst, pre_hit, cont;
  logic               rd_now, wr_now;
  logic [COL_W-1:0]   col_mask, col_k;
  logic [AW-1:0]      mem_addr;
  logic [NB-1:0]      wr_be;
  logic [DATA_W-1:0]  rd_keep;
  logic               unused_rows;

  always_comb begin
    any_open    = 1'b0;
    unused_rows = 1'b0;
    for (int i = 0; i < BANKS; i++) begin
      any_open    = any_open | bank_tab[i].open;
      unused_rows = unused_rows ^ (^bank_tab[i].row);
    end
  end

  always_comb begin
    cmd      = sdc_cs_n ? CMD_NOP : {sdc_ras_n, sdc_cas_n, sdc_we_n};
    tgt_open = bank_tab[sdc_ba].open;
    lmr_ok   = bl_valid(sdc_addr[2:0]) && (sdc_addr[6:4] == CL_2 || sdc_addr[6:4] == CL_3);
    err_now  = 1'b0;
    new_rd   = 1'b0;
    new_wr   = 1'b0;
    bst      = 1'b0;
    pre_hit  = 1'b0;
    case (cmd)
      CMD_LMR: err_now = any_open || !lmr_ok;
      CMD_ACT: err_now = tgt_open;
      CMD_RD: begin
        err_now = !tgt_open;
        new_rd  = tgt_open;
      end
      CMD_WR: begin
        err_now = !tgt_open;
        new_wr  = tgt_open;
      end
      CMD_BST: bst = 1'b1;
      CMD_PRE: pre_hit = burst_act && (sdc_addr[10] || sdc_ba == b_bank);
      CMD_REF: err_now = any_open;
      default: ;
    endcase

    // A new accepted column command, BURST STOP or a precharge of the burst bank
    // all pre-empt the running burst on this edge.
    cont   = burst_act && !new_rd && !new_wr && !bst && !pre_hit;
    rd_now = new_rd || (cont && !b_wr);
    wr_now = new_wr || (cont && b_wr);

    // Sequential order, wrapping inside the BL-aligned block.
    col_mask = COL_W'(b_len - LEN_W'(1));
    col_k    = (b_col & ~col_mask) | ((b_col + b_idx[COL_W-1:0]) & col_mask);

    if (new_rd || new_wr)
      mem_addr = {sdc_ba, bank_tab[sdc_ba].row[ROW_BITS-1:0], sdc_addr[COL_W-1:0]};
    else
      mem_addr = {b_bank, b_row, col_k};
  end

`ifdef SDC_DQM_EN
  logic [NB-1:0] dqm_q;
  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) dqm_q <= '0;
    else       dqm_q <= sdc_dqm;
  end
  always_comb begin
    wr_be = ~sdc_dqm;
    for (int b = 0; b < NB; b++) rd_keep[b*8 +: 8] = {8{~dqm_q[b]}};
  end
`else
  always_comb begin
    wr_be   = '1;
    rd_keep = '1;
  end
`endif

  sdr_resp_mem #(.DATA_W(DATA_W), .AW(AW)) u_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .wr    (wr_now),
    .be    (wr_be),
    .wdata (sdc_dq_i),
    .rdata (mem_rdata)
  );

  // ---------------- mode register and bank table ----------------
  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      for (int i = 0; i < BANKS; i++) bank_tab[i] <= '0;
      cl3      <= 1'b0;
      mode_len <= LEN_W'(1);
    end else begin
      if (cmd == CMD_LMR && !err_now) begin
        cl3      <= (sdc_addr[6:4] == CL_3);
        mode_len <= LEN_W'(bl_len(sdc_addr[2:0], COL_W));
      end
      if (cmd == CMD_ACT && !err_now) begin
        bank_tab[sdc_ba].open <= 1'b1;
        bank_tab[sdc_ba].row  <= ROW_MAX_W'(sdc_addr);
      end
      if (cmd == CMD_PRE) begin
        for (int i = 0; i < BANKS; i++) begin
          if (sdc_addr[10] || BA_W'(i) == sdc_ba) bank_tab[i].open <= 1'b0;
        end
      end
    end
  end

  // ---------------- burst column counter ----------------
  // Word 0 transfers on the command edge itself; b_idx is the index of the
  // next word to transfer.
  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      burst_act <= 1'b0;
      b_wr      <= 1'b0;
      b_bank    <= '0;
      b_row     <= '0;
      b_col     <= '0;
      b_idx     <= '0;
      b_len     <= LEN_W'(1);
    end else if (new_rd || new_wr) begin
      burst_act <= (mode_len != LEN_W'(1));
      b_wr      <= new_wr;
      b_bank    <= sdc_ba;
      b_row     <= bank_tab[sdc_ba].row[ROW_BITS-1:0];
      b_col     <= sdc_addr[COL_W-1:0];
      b_idx     <= LEN_W'(1);
      b_len     <= mode_len;
    end else if (cont) begin
      b_idx <= b_idx + LEN_W'(1);
      if (b_idx + LEN_W'(1) == b_len) burst_act <= 1'b0;
    end else if (bst || pre_hit) begin
      burst_act <= 1'b0;
    end
  end

  // ---------------- read pipeline ----------------
  // v0 tags the array output register, v1/d1 add the extra CL3 stage, and the
  // DQ output register is the last stage. A WRITE flushes everything in flight.
  logic              src_v;
  logic [DATA_W-1:0] src_d;

  always_comb begin
    src_v = cl3 ? v1 : v0;
    src_d = cl3 ? d1 : mem_rdata;
  end

  always_ff @(posedge clk or negedge rst2) begin
    if (!rst2) begin
      v0       <= 1'b0;
      v1       <= 1'b0;
      d1       <= '0;
      sdc_dq_o <= '0;
      sdc_dq_t <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      cmd_err  <= err_now;
      v0       <= rd_now;
      v1       <= v0 && !new_wr;
      d1       <= mem_rdata;
      sdc_dq_t <= src_v && !new_wr;
      if (src_v && !new_wr) sdc_dq_o <= src_d & rd_keep;
    end
  end

endmodule

// File: tb/tb_sdr_mem_responder.sv
module tb_sdr_mem_responder;

  localparam logic [2:0] NOP = 3'b111, ACT = 3'b011, RD = 3'b101, WR = 3'b100;
  localparam logic [2:0] BST = 3'b110, PRE = 3'b010, REF = 3'b001, LMR = 3'b000;

  logic        clk = 1'b0;
  logic        rst2 = 1'b0;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [1:0]  ba = '0;
  logic [11:0] addr = '0;
  logic [31:0] dq_i = '0;
  logic [31:0] dq_o;
  logic        dq_t;
  logic        cmd_err;
`ifdef SDC_DQM_EN
  logic [3:0]  dqm = '0;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdr_mem_responder dut (
    .clk       (clk),
    .rst2      (rst2),
    .sdc_cs_n  (cs_n),
    .sdc_ras_n (ras_n),
    .sdc_cas_n (cas_n),
    .sdc_we_n  (we_n),
    .sdc_ba    (ba),
    .sdc_addr  (addr),
    .sdc_dq_i  (dq_i),
    .sdc_dq_o  (dq_o),
    .sdc_dq_t  (dq_t),
    .cmd_err   (cmd_err)
`ifdef SDC_DQM_EN
    ,
    .sdc_dqm   (dqm)
`endif
  );

  typedef struct {
    logic [2:0]  c;
    logic [1:0]  b;
    logic [11:0] a;
    logic [31:0] d;
    logic        t;
    logic        e;
    logic        co;
    logic [31:0] o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                              input logic [31:0] d, input logic t, input logic e,
                              input logic co, input logic [31:0] o);
    vec_t v;
    v.c = c; v.b = b; v.a = a; v.d = d; v.t = t; v.e = e; v.co = co; v.o = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Apply one command, let the posedge sample it, and settle 1ns past the edge.
  task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                      input logic [31:0] d);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b; addr = a; dq_i = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset state ----
    @(posedge clk); @(posedge clk); #1;
    chk("rst_dq_t", dq_t, 0);
    chk("rst_dq_o", dq_o, 0);
    chk("rst_err", cmd_err, 0);
    @(negedge clk);
    rst2 = 1'b1;

    // ---- table: CL3 BL4 write/read, illegal commands ----
    tbl.push_back(mk(LMR, 0, 12'h032, 0,     0, 0, 0, 0));
    tbl.push_back(mk(ACT, 1, 12'h005, 0,     0, 0, 0, 0));
    tbl.push_back(mk(LMR, 0, 12'h032, 0,     0, 1, 0, 0));  // bank open
    tbl.push_back(mk(WR,  1, 12'h010, 'hA0,  0, 0, 0, 0));
    tbl.push_back(mk(NOP, 0, 12'h000, 'hA1,  0, 0, 0, 0));
    tbl.push_back(mk(NOP, 0, 12'h000, 'hA2,  0, 0, 0, 0));
    tbl.push_back(mk(NOP, 0, 12'h000, 'hA3,  0, 0, 0, 0));
    tbl.push_back(mk(RD,  1, 12'h012, 0,     0, 0, 0, 0));  // edge N
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     0, 0, 0, 0));  // after N+1
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     1, 0, 1, 'hA2));
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     1, 0, 1, 'hA3));
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     1, 0, 1, 'hA0));
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     1, 0, 1, 'hA1));
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     0, 0, 1, 'hA1));  // dq_o holds
    tbl.push_back(mk(RD,  2, 12'h000, 0,     0, 1, 0, 0));  // closed bank
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     0, 0, 0, 0));
    tbl.push_back(mk(ACT, 1, 12'h007, 0,     0, 1, 0, 0));  // already open
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     0, 0, 0, 0));
    tbl.push_back(mk(RD,  1, 12'h010, 0,     0, 0, 0, 0));  // row must still be 5
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     0, 0, 0, 0));
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     1, 0, 1, 'hA0));
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     1, 0, 1, 'hA1));
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     1, 0, 1, 'hA2));
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     1, 0, 1, 'hA3));
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     0, 0, 0, 0));
    tbl.push_back(mk(PRE, 0, 12'h400, 0,     0, 0, 0, 0));
    tbl.push_back(mk(LMR, 0, 12'h052, 0,     0, 1, 0, 0));  // bad CL code
    tbl.push_back(mk(REF, 0, 12'h000, 0,     0, 0, 0, 0));  // all idle: legal
    tbl.push_back(mk(NOP, 0, 12'h000, 0,     0, 0, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].b, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_dq_t", i), dq_t, tbl[i].t);
      chk($sformatf("vec%0d_err", i), cmd_err, tbl[i].e);
      if (tbl[i].co) chk($sformatf("vec%0d_dq_o", i), dq_o, tbl[i].o);
    end

    // ---- CL2 BL8 read cut by a write two cycles later ----
    step(LMR, 0, 12'h023, 0);     chk("s2_lmr_err", cmd_err, 0);
    step(ACT, 1, 12'h005, 0);
    step(RD,  1, 12'h010, 0);     chk("s2_rd_t0", dq_t, 0);
    step(NOP, 0, 0, 0);           chk("s2_w0_t", dq_t, 1); chk("s2_w0_o", dq_o, 'hA0);
    step(WR,  1, 12'h020, 'hB0);  chk("s2_wr_t", dq_t, 0);
    for (int k = 1; k < 8; k++) begin
      step(NOP, 0, 0, 32'hB0 + 32'(k));
      chk($sformatf("s2_wr%0d_t", k), dq_t, 0);
    end
    step(RD, 1, 12'h020, 0);
    for (int k = 0; k < 8; k++) begin
      step(NOP, 0, 0, 0);
      chk($sformatf("s2_rb%0d_t", k), dq_t, 1);
      chk($sformatf("s2_rb%0d_o", k), dq_o, 32'hB0 + 32'(k));
    end
    step(NOP, 0, 0, 0);           chk("s2_end_t", dq_t, 0);

    // ---- full page write across the page end, stopped after 4 words ----
    step(PRE, 0, 12'h400, 0);
    step(LMR, 0, 12'h027, 0);     chk("s3_lmr_err", cmd_err, 0);
    step(ACT, 0, 12'h003, 0);
    step(WR,  0, 12'h002, 'hCC);
    step(BST, 0, 0, 0);
    step(WR,  0, 12'h0FE, 'hD0);
    step(NOP, 0, 0, 'hD1);
    step(NOP, 0, 0, 'hD2);
    step(NOP, 0, 0, 'hD3);
    step(BST, 0, 0, 'hD4);
    step(NOP, 0, 0, 'hD5);
    step(RD,  0, 12'h0FE, 0);     chk("s3_rd_t0", dq_t, 0);
    for (int k = 0; k < 4; k++) begin
      step(NOP, 0, 0, 0);
      chk($sformatf("s3_rb%0d_t", k), dq_t, 1);
      chk($sformatf("s3_rb%0d_o", k), dq_o, 32'hD0 + 32'(k));
    end
    step(BST, 0, 0, 0);           chk("s3_col2_t", dq_t, 1); chk("s3_col2_o", dq_o, 'hCC);
    step(NOP, 0, 0, 0);           chk("s3_drain_t", dq_t, 0);

    // ---- reset in the middle of a read burst ----
    step(RD,  0, 12'h000, 0);
    step(NOP, 0, 0, 0);           chk("s4_pre_t", dq_t, 1);
    step(NOP, 0, 0, 0);
    #2 rst2 = 1'b0;
    #1;
    chk("s4_async_t", dq_t, 0);
    chk("s4_async_o", dq_o, 0);
    @(negedge clk);
    rst2 = 1'b1;
    step(RD,  0, 12'h040, 0);     chk("s4_rd_err", cmd_err, 1); chk("s4_rd_t", dq_t, 0);
    step(NOP, 0, 0, 0);           chk("s4_err_clr", cmd_err, 0); chk("s4_idle_t", dq_t, 0);
    step(ACT, 0, 12'h003, 0);     chk("s4_act_err", cmd_err, 0);
    step(WR,  0, 12'h040, 'hE0);
    step(NOP, 0, 0, 'hE1);
    step(RD,  0, 12'h040, 0);     chk("s4_cl_t0", dq_t, 0);
    step(NOP, 0, 0, 0);           chk("s4_cl2_t", dq_t, 1); chk("s4_cl2_o", dq_o, 'hE0);
    step(NOP, 0, 0, 0);           chk("s4_bl1_t", dq_t, 0);

`ifdef SDC_DQM_EN
    // ---- byte masks ----
    step(WR, 0, 12'h050, 32'hFFFF_FFFF);
    dqm = 4'b0101;
    step(WR, 0, 12'h050, 32'h1122_3344);
    dqm = 4'b0000;
    step(RD, 0, 12'h050, 0);
    step(NOP, 0, 0, 0);           chk("dqm_wr_o", dq_o, 32'h11FF_33FF);
    dqm = 4'b0001;
    step(RD, 0, 12'h050, 0);
    dqm = 4'b0000;
    step(NOP, 0, 0, 0);           chk("dqm_rd_o", dq_o, 32'h11FF_3300);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
